sine_dds_scheduler: RTL and testbench

SINE_DDS_SCHEDULER -- requirements
Module: sine_dds_scheduler

---
 rtl/sine_dds_scheduler.sv | 161 ++++++++++++++++
 tb/tb_sine_dds_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sine_dds_scheduler.sv
// Time-multiplexed phase-accumulator scheduler: one shared sine lookup serves NCH channels.
// Each sample_tick issues one phase per channel, collects the results and publishes them together.
module sine_dds_scheduler #(
  parameter int NCH = 4,
  parameter int LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_tick,
  input  logic                     cfg_we,
  input  logic [$clog2(NCH)-1:0]   cfg_ch,
  input  logic [8:0]               cfg_inc,
  input  logic                     cfg_en,
  input  logic                     overrun_clr,
  output logic [8:0]               sine_phase,
  input  logic [9:0]               sine_data,
  output logic [10*NCH-1:0]        ch_sample,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic [1:0]               dbg_state
);

  localparam int CW = $clog2(NCH);
  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [9:0] MID = 10'd512;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Handshake: sample_tick is a one-cycle request taken only in IDLE (dropped and
  // flagged as overrun otherwise); sample_valid is a one-cycle strobe, no back-pressure.
  state_t          state, state_n;
  logic [CW-1:0]   slot, slot_n;
  logic [LW-1:0]   drain_cnt, drain_cnt_n;
  logic            issue;

  logic [8:0]      acc    [NCH];
  logic [8:0]      inc    [NCH];
  logic            en     [NCH];
  logic [9:0]      shadow [NCH];

  logic            p_v  [LAT];
  logic [CW-1:0]   p_ch [LAT];
  logic            p_en [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      slot      <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      slot      <= slot_n;
      drain_cnt <= drain_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    slot_n      = slot;
    drain_cnt_n = drain_cnt;
    issue       = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          state_n = ISSUE;
          slot_n  = '0;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (slot == CW'(NCH - 1)) begin
          state_n     = DRAIN;
          drain_cnt_n = '0;
        end else begin
          slot_n = slot + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == LW'(LAT - 1)) state_n = DONE;
        else drain_cnt_n = drain_cnt + 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign sine_phase = issue ? acc[slot] : 9'd0;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  // Configuration registers; an issue in the same cycle still sees the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        inc[k] <= '0;
        en[k]  <= 1'b0;
      end
    end else if (cfg_we && (int'(cfg_ch) < NCH)) begin
      inc[cfg_ch] <= cfg_inc;
      en[cfg_ch]  <= cfg_en;
    end
  end

  // Phase accumulators advance only when their slot issues; wrap is mod 512.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) acc[k] <= '0;
    end else if (issue && en[slot]) begin
      acc[slot] <= acc[slot] + inc[slot];
    end
  end

  // Slot tags travel alongside the lookup latency so each result lands in its own shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        p_v[i]  <= 1'b0;
        p_ch[i] <= '0;
        p_en[i] <= 1'b0;
      end
    end else begin
      p_v[0]  <= issue;
      p_ch[0] <= slot;
      p_en[0] <= en[slot];
      for (int i = 1; i < LAT; i++) begin
        p_v[i]  <= p_v[i-1];
        p_ch[i] <= p_ch[i-1];
        p_en[i] <= p_en[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) shadow[k] <= MID;
    end else if (p_v[LAT-1]) begin
      shadow[p_ch[LAT-1]] <= p_en[LAT-1] ? sine_data : MID;
    end
  end

  // Publishing all shadows at once keeps ch_sample coherent across channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_sample    <= {NCH{MID}};
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= (state == DONE);
      if (state == DONE) begin
        for (int k = 0; k < NCH; k++) ch_sample[10*k +: 10] <= shadow[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else if (sample_tick && busy) overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_sine_dds_scheduler.sv
// Directed bench for sine_dds_scheduler with a registered quarter-table sine lookup model.
// Expected samples are hand-computed with q(i) = 3*i + 7.
module tb_sine_dds_scheduler;

  localparam int NCH = 4;
  localparam int LAT = 1;
  localparam logic [9:0] M = 10'd512;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_tick = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [8:0]        cfg_inc = '0;
  logic              cfg_en = 1'b0;
  logic              overrun_clr = 1'b0;
  logic [8:0]        sine_phase;
  logic [9:0]        sine_data = '0;
  logic [10*NCH-1:0] ch_sample;
  logic              sample_valid;
  logic              busy;
  logic              overrun;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  logic [10*NCH-1:0] exp_q[$];

  logic [8:0]  ph [NCH];
  int          valid_n, valid_at;
  logic [10:0] busy_bits;

  sine_dds_scheduler #(.NCH(NCH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_en(cfg_en),
    .overrun_clr(overrun_clr), .sine_phase(sine_phase), .sine_data(sine_data),
    .ch_sample(ch_sample), .sample_valid(sample_valid), .busy(busy),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // Clock and lookup model
  always #5 clk = ~clk;

  function automatic logic [9:0] q(input int i);
    return 10'(3 * i + 7);
  endfunction

  function automatic logic [9:0] lut(input logic [8:0] p);
    int idx;
    idx = int'(p[6:0]);
    case (p[8:7])
      2'd0:    return M + q(idx);
      2'd1:    return M + q(127 - idx);
      2'd2:    return M - q(idx);
      default: return M - q(127 - idx);
    endcase
  endfunction

  always @(posedge clk) sine_data <= lut(sine_phase);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every sample_valid must match the next queued sample set
  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 64'(sample_valid), 64'd0);
      else check("ch_sample", 64'(ch_sample), 64'(exp_q.pop_front()));
    end
  end

  // Drivers
  task automatic cfg_write(input int ch, input int incv, input logic env);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_inc = 9'(incv); cfg_en = env;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_round(input int xtick_at, input int clr_at, input int rst_at,
                          input int cfg_at, input int cfg_incv);
    logic [10*NCH-1:0] pre;
    @(negedge clk);
    pre = ch_sample;
    sample_tick = 1'b1;
    overrun_clr = (clr_at == 0);
    valid_n = 0; valid_at = 0; busy_bits = '0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n <= NCH) ph[n-1] = sine_phase;
      busy_bits[n] = busy;
      if (sample_valid) begin valid_n++; valid_at = n; end
      if (n == 6 && rst_at < 0) check("hold_between_valid", 64'(ch_sample), 64'(pre));
      sample_tick = (n == xtick_at);
      overrun_clr = (n == clr_at);
      cfg_we = (n == cfg_at); cfg_ch = 2'd0; cfg_inc = 9'(cfg_incv); cfg_en = 1'b1;
      rst_n = (n != rst_at);
      if (n == rst_at) begin
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_phase", 64'(sine_phase), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_ch_sample", 64'(ch_sample), 64'({M, M, M, M}));
      end
    end
    sample_tick = 1'b0; overrun_clr = 1'b0; cfg_we = 1'b0; rst_n = 1'b1;
  endtask

  task automatic std_round(input logic [39:0] exp_s, input logic [8:0] p0,
                           input logic [8:0] p1, input logic [8:0] p2, input string tag);
    exp_q.push_back(exp_s);
    do_round(-1, -1, -1, -1, 0);
    check({tag, "_valid_at"}, 64'(valid_at), 64'd7);
    check({tag, "_valid_n"}, 64'(valid_n), 64'd1);
    check({tag, "_busy"}, 64'(busy_bits), 64'b000_0111_1110);
    check({tag, "_phases"}, 64'({ph[2], ph[1], ph[0]}), 64'({p2, p1, p0}));
  endtask

  initial begin : main
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(sample_valid), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);
    check("reset_phase", 64'(sine_phase), 64'd0);
    check("reset_ch_sample", 64'(ch_sample), 64'({M, M, M, M}));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All channels disabled
    std_round({M, M, M, M}, 9'd0, 9'd0, 9'd0, "dis");
    check("dis_phase3", 64'(ph[3]), 64'd0);

    // ch0 inc=128: phases 0,128,256,384,0
    cfg_write(0, 128, 1'b1);
    std_round({M, M, M, 10'd519}, 9'd0,   9'd0, 9'd0, "c0r0");
    std_round({M, M, M, 10'd900}, 9'd128, 9'd0, 9'd0, "c0r1");
    std_round({M, M, M, 10'd505}, 9'd256, 9'd0, 9'd0, "c0r2");
    std_round({M, M, M, 10'd124}, 9'd384, 9'd0, 9'd0, "c0r3");
    std_round({M, M, M, 10'd519}, 9'd0,   9'd0, 9'd0, "c0r4");

    // ch0 disabled holds phase 128; ch1 inc=511 wraps down
    cfg_write(0, 128, 1'b0);
    cfg_write(1, 511, 1'b1);
    std_round({M, M, 10'd519, M}, 9'd128, 9'd0,   9'd0, "c1r0");
    std_round({M, M, 10'd505, M}, 9'd128, 9'd511, 9'd0, "c1r1");
    std_round({M, M, 10'd502, M}, 9'd128, 9'd510, 9'd0, "c1r2");

    // Tick while busy: ignored, overrun set
    exp_q.push_back({M, M, 10'd499, M});
    do_round(3, -1, -1, -1, 0);
    check("ovr_valid_n", 64'(valid_n), 64'd1);
    check("ovr_valid_at", 64'(valid_at), 64'd7);
    check("ovr_phase1", 64'(ph[1]), 64'd509);
    check("ovr_set", 64'(overrun), 64'd1);
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    check("ovr_clr", 64'(overrun), 64'd0);

    // Clear coincident with a busy tick: overrun stays set
    exp_q.push_back({M, M, 10'd496, M});
    do_round(3, 3, -1, -1, 0);
    check("ovr_clr_vs_set", 64'(overrun), 64'd1);
    check("ovr2_valid_n", 64'(valid_n), 64'd1);

    // Tick with clear in IDLE: round starts, overrun cleared
    exp_q.push_back({M, M, 10'd493, M});
    do_round(-1, 0, -1, -1, 0);
    check("idle_clr_overrun", 64'(overrun), 64'd0);
    check("idle_clr_valid_at", 64'(valid_at), 64'd7);

    // Reset mid-round at T+3: aborted, no sample_valid
    do_round(-1, -1, 3, -1, 0);
    check("abort_valid_n", 64'(valid_n), 64'd0);
    check("abort_busy", 64'(busy_bits), 64'b000_0000_1110);
    std_round({M, M, M, M}, 9'd0, 9'd0, 9'd0, "post_rst");

    // cfg write to ch0 during its own slot: old inc this round, new inc next
    cfg_write(0, 128, 1'b1);
    exp_q.push_back({M, M, M, 10'd519});
    do_round(-1, -1, -1, 1, 64);
    check("cfgslot_phase0", 64'(ph[0]), 64'd0);
    std_round({M, M, M, 10'd900}, 9'd128, 9'd0, 9'd0, "cfg_r1");
    std_round({M, M, M, 10'd708}, 9'd192, 9'd0, 9'd0, "cfg_r2");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
